// File: rtl/ldtu_rx_pkg.sv
// Shared constants, state encoding and word classifier for the LiTe-DTU receive path.
package ldtu_rx_pkg;

  localparam int          Nbits_32       = 32;
  localparam logic [31:0] idle_patternEA = 32'hEAAAAAAA;
  localparam logic [31:0] idle_pattern5A = 32'h5A5A5A5A;
  localparam logic [31:0] flush_pattern  = 32'hFEEDC0DE;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'b00,
    ST_LOCKED   = 2'b01,
    ST_FLUSH    = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    WC_IDLE    = 2'b00,
    WC_SYNCH   = 2'b01,
    WC_FLUSH   = 2'b10,
    WC_PAYLOAD = 2'b11
  } wclass_e;

  // Synch is tested before idle so a synch word programmed to an idle value still wins.
  function automatic wclass_e classify(input logic [31:0] w, input logic [31:0] synch);
    if (w == flush_pattern)                             return WC_FLUSH;
    else if (w == synch)                                return WC_SYNCH;
    else if (w == idle_patternEA || w == idle_pattern5A) return WC_IDLE;
    else                                                return WC_PAYLOAD;
  endfunction

endpackage

// File: rtl/ldtu_rx_fifo.sv
// Synchronous payload FIFO with clear, registered read data and drop indication.
module ldtu_rx_fifo
  import ldtu_rx_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         dout_vld,
  output logic         empty,
  output logic         full,
  output logic         drop
);

  logic [PTR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [W-1:0]   dout_q, dout_d;
  logic           vld_q, vld_d;
  logic [W-1:0]   mem_q [DEPTH];
  logic           pop_ok, push_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                 (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign pop_ok  = pop & ~empty & ~clr;
  assign push_ok = push & (~full | pop_ok) & ~clr;
  assign drop    = push & full & ~pop_ok & ~clr;

  always_comb begin
    dout_d   = dout_q;
    vld_d    = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      dout_d = pop_ok ? mem_q[rd_ptr_q[PTR_W-1:0]] : W'(idle_patternEA);
      vld_d  = pop_ok;
    end
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout_q   <= W'(idle_patternEA);
      vld_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dout_q   <= dout_d;
      vld_q    <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[PTR_W-1:0]] <= din;
  end

  assign dout     = dout_q;
  assign dout_vld = vld_q;

endmodule

// File: rtl/ldtu_rx_word_decoder.sv
// LiTe-DTU receive word decoder: classifies words, locks on idles, buffers payload.
module ldtu_rx_word_decoder
  import ldtu_rx_pkg::*;
#(
  parameter int Nbits_32  = 32,
  parameter int FifoDepth = 16,
  parameter int bits_ptr  = 4,
  parameter int LockCount = 4
) (
  input  logic                CLK,
  input  logic                rst_b,
  input  logic [Nbits_32-1:0] data_in_32,
  input  logic                word_valid,
  input  logic [Nbits_32-1:0] synch_pattern,
  input  logic                read_signal,
  output logic [Nbits_32-1:0] data_out_32,
  output logic                data_valid,
  output logic                empty_signal,
  output logic                full_signal,
  output logic                locked,
  output logic                flush_seen,
  output logic                synch_seen,
  output logic                overflow
);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d, cnt_inc;
  logic       flush_seen_q, flush_seen_d;
  logic       synch_seen_q, synch_seen_d;
  logic       overflow_q, overflow_d;
  logic       push, clr, drop;
  wclass_e    cls;

  assign cls     = classify(32'(data_in_32), 32'(synch_pattern));
  assign cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_seen_d = 1'b0;
    synch_seen_d = 1'b0;
    push         = 1'b0;
    clr          = 1'b0;
    if (word_valid) begin
      if (cls == WC_FLUSH) begin
        if (state_q != ST_FLUSH) begin
          state_d      = ST_FLUSH;
          flush_seen_d = 1'b1;
          clr          = 1'b1;
          cnt_d        = '0;
        end
      end else if (state_q == ST_LOCKED) begin
        push         = (cls == WC_PAYLOAD);
        synch_seen_d = (cls == WC_SYNCH);
      end else begin
        // Leaving FLUSH: this same word is judged by the unlocked rules.
        state_d = ST_UNLOCKED;
        case (cls)
          WC_IDLE: begin
            if (cnt_inc >= 4'(LockCount)) begin
              state_d = ST_LOCKED;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          WC_SYNCH: begin
            synch_seen_d = 1'b1;
            cnt_d        = '0;
          end
          default: cnt_d = '0;
        endcase
      end
    end
    overflow_d = clr ? 1'b0 : (overflow_q | drop);
  end

  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= ST_UNLOCKED;
      cnt_q        <= '0;
      flush_seen_q <= 1'b0;
      synch_seen_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_seen_q <= flush_seen_d;
      synch_seen_q <= synch_seen_d;
      overflow_q   <= overflow_d;
    end
  end

  ldtu_rx_fifo #(
    .W    (Nbits_32),
    .DEPTH(FifoDepth),
    .PTR_W(bits_ptr)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (rst_b),
    .push    (push),
    .pop     (read_signal),
    .clr     (clr),
    .din     (data_in_32),
    .dout    (data_out_32),
    .dout_vld(data_valid),
    .empty   (empty_signal),
    .full    (full_signal),
    .drop    (drop)
  );

  assign locked     = (state_q == ST_LOCKED);
  assign flush_seen = flush_seen_q;
  assign synch_seen = synch_seen_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ldtu_rx_word_decoder.sv
// Randomized + directed bench for ldtu_rx_word_decoder against a queue-based reference model.
module tb_ldtu_rx_word_decoder;

  localparam logic [31:0] EA  = 32'hEAAAAAAA;
  localparam logic [31:0] A5  = 32'h5A5A5A5A;
  localparam logic [31:0] FL  = 32'hFEEDC0DE;
  localparam logic [31:0] SYN = 32'h12345678;
  localparam int DEPTH = 16;
  localparam int LOCKN = 4;
  localparam int M_UNL = 0, M_LCK = 1, M_FLS = 2;

  logic        CLK = 1'b0;
  logic        rst_b;
  logic [31:0] data_in_32;
  logic        word_valid;
  logic [31:0] synch_pattern;
  logic        read_signal;
  logic [31:0] data_out_32;
  logic        data_valid, empty_signal, full_signal, locked;
  logic        flush_seen, synch_seen, overflow;

  ldtu_rx_word_decoder dut (
    .CLK(CLK), .rst_b(rst_b), .data_in_32(data_in_32), .word_valid(word_valid),
    .synch_pattern(synch_pattern), .read_signal(read_signal),
    .data_out_32(data_out_32), .data_valid(data_valid), .empty_signal(empty_signal),
    .full_signal(full_signal), .locked(locked), .flush_seen(flush_seen),
    .synch_seen(synch_seen), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int          m_st, m_cnt;
  logic [31:0] m_q[$];
  logic [31:0] m_dout;
  logic        m_vld, m_ovf, m_fs, m_ss;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = M_UNL; m_cnt = 0; m_q.delete();
    m_dout = EA; m_vld = 0; m_ovf = 0; m_fs = 0; m_ss = 0;
  endtask

  task automatic model_step(input logic v, input logic [31:0] d, input logic r);
    bit is_fl, is_sy, is_id, entry;
    is_fl = (d == FL);
    is_sy = !is_fl && (d == synch_pattern);
    is_id = !is_fl && !is_sy && (d == EA || d == A5);
    entry = v && is_fl && (m_st != M_FLS);
    m_fs = 0; m_ss = 0;
    if (r) begin
      if (entry || m_q.size() == 0) begin m_dout = EA; m_vld = 0; end
      else begin m_dout = m_q.pop_front(); m_vld = 1; end
    end else m_vld = 0;
    if (entry) begin m_q.delete(); m_ovf = 0; end
    if (v) begin
      if (m_st == M_FLS && !is_fl) m_st = M_UNL;
      if (entry) begin
        m_st = M_FLS; m_fs = 1; m_cnt = 0;
      end else if (m_st == M_UNL) begin
        if (is_sy) m_ss = 1;
        if (is_id) begin
          m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
          if (m_cnt >= LOCKN) begin m_st = M_LCK; m_cnt = 0; end
        end else m_cnt = 0;
      end else if (m_st == M_LCK) begin
        if (is_sy) m_ss = 1;
        if (!is_fl && !is_sy && !is_id) begin
          if (m_q.size() < DEPTH) m_q.push_back(d); else m_ovf = 1;
        end
      end
    end
  endtask

  task automatic check_all(input string p);
    chk({p, "_dout"},   data_out_32,  m_dout);
    chk({p, "_dvalid"}, 32'(data_valid),   32'(m_vld));
    chk({p, "_empty"},  32'(empty_signal), 32'(m_q.size() == 0));
    chk({p, "_full"},   32'(full_signal),  32'(m_q.size() == DEPTH));
    chk({p, "_locked"}, 32'(locked),       32'(m_st == M_LCK));
    chk({p, "_flush"},  32'(flush_seen),   32'(m_fs));
    chk({p, "_synch"},  32'(synch_seen),   32'(m_ss));
    chk({p, "_ovf"},    32'(overflow),     32'(m_ovf));
  endtask

  task automatic cyc(input logic v, input logic [31:0] d, input logic r, input string p);
    word_valid = v; data_in_32 = d; read_signal = r;
    model_step(v, d, r);
    @(posedge CLK); #1;
    check_all(p);
  endtask

  // Asserts reset away from any clock edge and checks outputs before the next edge.
  task automatic do_reset(input string p);
    word_valid = 0; read_signal = 0; data_in_32 = EA;
    rst_b = 1'b0;
    #2;
    model_reset();
    check_all(p);
    chk({p, "_rst_dout"}, data_out_32, EA);
    @(negedge CLK);
    rst_b = 1'b1;
  endtask

  task automatic lock_up(input string p);
    for (int i = 0; i < LOCKN; i++) cyc(1, EA, 0, p);
  endtask

  initial begin
    synch_pattern = SYN;
    word_valid = 0; read_signal = 0; data_in_32 = EA;
    rst_b = 1'b0;
    #12;
    do_reset("rst");

    // 1: lock on the 4th idle
    for (int i = 0; i < LOCKN - 1; i++) cyc(1, EA, 0, "t1");
    chk("t1_not_yet", 32'(locked), 32'd0);
    cyc(1, EA, 0, "t1");
    chk("t1_locked", 32'(locked), 32'd1);

    // 2: interleaved payload, three reads, then read on empty
    for (int i = 1; i <= 3; i++) begin cyc(1, 32'(i), 0, "t2"); cyc(1, EA, 0, "t2"); end
    for (int i = 1; i <= 3; i++) begin
      cyc(0, EA, 1, "t2r");
      chk("t2_word", data_out_32, 32'(i));
    end
    cyc(0, EA, 1, "t2e");
    chk("t2_idle_rd", data_out_32, EA);

    // 3: fill, overflow on 17th, drain 1..16
    do_reset("t3rst");
    lock_up("t3");
    for (int i = 1; i <= 17; i++) begin
      cyc(1, 32'(i), 0, "t3");
      if (i == 16) chk("t3_full", 32'(full_signal), 32'd1);
    end
    chk("t3_ovf", 32'(overflow), 32'd1);
    for (int i = 1; i <= 16; i++) cyc(0, EA, 1, "t3r");
    chk("t3_last", data_out_32, 32'd16);

    // 4: flush run then idle; counter restarts at 1
    do_reset("t4rst");
    lock_up("t4");
    for (int i = 0; i < 5; i++) cyc(1, 32'h100 + 32'(i), 0, "t4");
    cyc(1, FL, 1, "t4f");
    chk("t4_pulse", 32'(flush_seen), 32'd1);
    chk("t4_flush_rd", data_out_32, EA);
    cyc(1, FL, 0, "t4f"); cyc(1, FL, 0, "t4f");
    cyc(1, EA, 0, "t4");
    chk("t4_unlocked", 32'(locked), 32'd0);
    for (int i = 0; i < LOCKN - 1; i++) cyc(1, EA, 0, "t4l");
    chk("t4_relock", 32'(locked), 32'd1);

    // 5: synch locked and unlocked
    cyc(1, SYN, 0, "t5");
    chk("t5_synch_lck", 32'(synch_seen), 32'd1);
    do_reset("t5rst");
    for (int i = 0; i < 3; i++) cyc(1, EA, 0, "t5");
    cyc(1, SYN, 0, "t5");
    for (int i = 0; i < 3; i++) cyc(1, EA, 0, "t5");
    chk("t5_nolock", 32'(locked), 32'd0);
    cyc(1, EA, 0, "t5");
    chk("t5_lock", 32'(locked), 32'd1);

    // 6: async reset with full FIFO
    for (int i = 0; i < DEPTH; i++) cyc(1, 32'hA000 + 32'(i), 0, "t6");
    chk("t6_full", 32'(full_signal), 32'd1);
    do_reset("t6rst");

    // Randomized phases with varying read pressure
    for (int ph = 0; ph < 4; ph++) begin
      int rdp;
      rdp = (ph == 0) ? 0 : (ph == 1) ? 10 : (ph == 2) ? 50 : 90;
      synch_pattern = (ph == 2) ? EA : SYN;
      for (int n = 0; n < 700; n++) begin
        logic v, r;
        logic [31:0] d;
        int k;
        v = ($urandom_range(7) != 0);
        r = ($urandom_range(99) < rdp);
        k = $urandom_range(99);
        if (k < 60)      d = $urandom_range(1) ? EA : A5;
        else if (k < 90) d = $urandom;
        else if (k < 97) d = SYN;
        else             d = FL;
        cyc(v, d, r, "rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/ldtu_rx_word_decoder.md
Name: ldtu_rx_word_decoder

Overview:
- Back-end receiver for the LiTe-DTU 32-bit output word stream, after deserialisation.
- Classifies each received word as one of: flush marker 0xFEEDC0DE, synch pattern, idle (0xEAAAAAAA / 0x5A5A5A5A) or payload.
- Acquires lock on the idle stream and buffers payload words in a small FIFO for downstream readout.
- Counterpart of the output FIFO/serialiser path.

Parameters:
- Nbits_32, 32, word width.
- FifoDepth, 16, payload buffer depth in words.
- bits_ptr, 4, log2(FifoDepth).
- LockCount, 4, consecutive idle words required to lock (range 1..15).
- idle_patternEA, 32'hEAAAAAAA, primary idle word.
- idle_pattern5A, 32'h5A5A5A5A, alternate idle word.
- flush_pattern, 32'hFEEDC0DE, flush marker.

Ports:
- CLK, in, 1, clock.
- rst_b, in, 1, asynchronous active-low reset.
- data_in_32, in, 32, received word.
- word_valid, in, 1, data_in_32 valid this cycle.
- synch_pattern, in, 32, programmed synch word; quasi-static.
- read_signal, in, 1, pop request from downstream.
- data_out_32, out, 32, registered read data.
- data_valid, out, 1, data_out_32 holds a popped payload word.
- empty_signal, out, 1, FIFO empty.
- full_signal, out, 1, FIFO full.
- locked, out, 1, FSM in LOCKED.
- flush_seen, out, 1, one-cycle pulse on the first flush marker of a run.
- synch_seen, out, 1, one-cycle pulse per synch word received.
- overflow, out, 1, sticky; a payload word was dropped.

Behaviour:
- Reset: asynchronous on rst_b=0, one clock (CLK), active-low. All state is cleared: FSM=UNLOCKED, idle counter=0, FIFO pointers=0.
- Outputs during reset:
  - data_out_32 = idle_patternEA.
  - data_valid = 0, full_signal = 0, locked = 0, flush_seen = 0, synch_seen = 0, overflow = 0.
  - empty_signal = 1.
- Classification is combinational on data_in_32 and applies only when word_valid=1. Priority is flush > synch > idle > payload. If synch_pattern equals an idle word, synch wins.
- FSM states: UNLOCKED, LOCKED, FLUSH. State and pulse outputs update on the CLK edge following the valid word.
- UNLOCKED:
  - Idle word: counter +1 (saturating). On reaching LockCount, go to LOCKED and clear the counter.
  - Payload word: discarded; counter cleared.
  - Synch word: synch_seen pulse; counter cleared.
  - Flush word: go to FLUSH.
- LOCKED:
  - Idle word: discarded.
  - Payload word: pushed to FIFO.
  - Synch word: synch_seen pulse; not stored; stays LOCKED.
  - Flush word: go to FLUSH.
- FLUSH:
  - On entry: flush_seen pulses once, the FIFO is cleared (pointers reset, empty=1, full=0) and overflow is cleared.
  - Consecutive flush words: stay in FLUSH, no further pulses.
  - First valid non-flush word: go to UNLOCKED. That word is classified by the UNLOCKED rules in the same cycle, so an idle word leaves counter=1.
- word_valid=0: no state change, counter holds.
- FIFO:
  - Pointers are bits_ptr+1 bits wide. empty = pointers equal. full = low bits equal and MSBs differ.
  - Push latency: a payload word on cycle n becomes visible at n+1 (empty_signal falls at n+1).
- Read:
  - read_signal=1 with empty=0: data_out_32 ← head word and data_valid=1 at the next edge; read pointer advances.
  - read_signal=1 with empty=1: data_out_32 ← idle_patternEA and data_valid=0.
  - read_signal=0: data_out_32 holds its value and data_valid=0.
- Simultaneous push and pop:
  - Not empty: both occur and occupancy is unchanged.
  - Full: the pop frees a slot, so the push is accepted and no overflow occurs.
  - Empty: the read returns idle and the word is stored.
- Push while full without a pop: the word is dropped and overflow sets. overflow stays set until reset or FLUSH entry.
- A flush word while a read is in progress: the FIFO is cleared and the concurrent read returns idle_patternEA with data_valid=0.

Decomposition:
- Package ldtu_rx_pkg holds:
  - The pattern constants (idle EA/5A, flush).
  - The state encoding (UNLOCKED=2'b00, LOCKED=2'b01, FLUSH=2'b10).
  - The word-class encoding (IDLE, SYNCH, FLUSH, PAYLOAD).
- One sub-module, ldtu_rx_fifo: a parameterised synchronous FIFO with push, pop, clear, full, empty and registered read data.
- Classifier and FSM stay in the top.

Test Plan:
1. Reset then LockCount=4 EA words -> locked=1 on the edge after the 4th word; empty_signal=1; data_out_32=0xEAAAAAAA.
2. Lock, then send 0x00000001..0x00000003 interleaved with EA idles, then read 3 times -> data_out_32=1,2,3 with data_valid=1. A 4th read -> data_out_32=0xEAAAAAAA, data_valid=0.
3. Lock, push 17 payload words with no reads -> full_signal=1 after 16 words, overflow=1 after the 17th. Then 16 reads return words 1..16.
4. Locked with 5 words buffered, send 3×0xFEEDC0DE then EA -> flush_seen pulses once, empty_signal=1, overflow=0, locked=0; the trailing EA leaves counter=1.
5. synch_pattern=0x12345678, received while locked and while unlocked -> synch_seen pulses each time, word not stored. The unlocked case resets the idle count: 3 EA, synch, 3 EA gives no lock; a 4th EA gives lock.
6. Assert rst_b=0 asynchronously mid-stream with a full FIFO -> all outputs return to reset values immediately, without a CLK edge.
